// File: rtl/serial_deser_rx.sv
// Serial-to-parallel frame receiver: sof-delimited frames of N data bits plus
// an optional even-parity bit, qualified per bit by bit_en.
module serial_deser_rx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PAR_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sof,
  input  logic         bit_en,
  input  logic         sdin,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  output logic         busy,
  output logic         frame_err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   shift_q;
  logic [N-1:0]   shift_d;
  logic [N-1:0]   dout_q;
  logic           valid_q;
  logic           busy_q;
  logic           err_q;
  logic           last_bit_d;
  logic           err_d;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_d = {shift_q[N-2:0], sdin};
    end else begin : g_lsb_first
      assign shift_d = {sdin, shift_q[N-1:1]};
    end
  endgenerate

  assign last_bit_d = (cnt_q == CW'(N - 1));
  // Even parity over the data word and the received parity bit.
  assign err_d      = (^shift_q) ^ sdin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (sof) begin
        // A new frame always wins, aborting any partial one and its bit.
        state_q <= DATA;
        cnt_q   <= '0;
        shift_q <= '0;
        busy_q  <= 1'b1;
      end else if (bit_en) begin
        case (state_q)
          DATA: begin
            shift_q <= shift_d;
            if (last_bit_d) begin
              if (PAR_EN) begin
                state_q <= PARITY;
              end else begin
                dout_q  <= shift_d;
                err_q   <= 1'b0;
                valid_q <= 1'b1;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PARITY: begin
            dout_q  <= shift_q;
            err_q   <= err_d;
            valid_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_serial_deser_rx.sv
// Bench for serial_deser_rx: three configurations share one stimulus stream and
// are checked every cycle against a bit-list frame model.
module tb_serial_deser_rx;

  logic clk;
  logic reset;
  logic sof;
  logic bit_en;
  logic sdin;

  logic [7:0] dout0, dout1;
  logic [4:0] dout2;
  logic       valid0, valid1, valid2;
  logic       busy0, busy1, busy2;
  logic       err0, err1, err2;

  int cmp_count = 0;
  int err_count = 0;

  serial_deser_rx #(.N(8), .MSB_FIRST(1'b1), .PAR_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .sof(sof), .bit_en(bit_en), .sdin(sdin),
    .dout(dout0), .dout_valid(valid0), .busy(busy0), .frame_err(err0));
  serial_deser_rx #(.N(8), .MSB_FIRST(1'b0), .PAR_EN(1'b1)) u1 (
    .clk(clk), .reset(reset), .sof(sof), .bit_en(bit_en), .sdin(sdin),
    .dout(dout1), .dout_valid(valid1), .busy(busy1), .frame_err(err1));
  serial_deser_rx #(.N(5), .MSB_FIRST(1'b0), .PAR_EN(1'b0)) u2 (
    .clk(clk), .reset(reset), .sof(sof), .bit_en(bit_en), .sdin(sdin),
    .dout(dout2), .dout_valid(valid2), .busy(busy2), .frame_err(err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_n(int d);
    return (d == 2) ? 5 : 8;
  endfunction
  function automatic bit cfg_msb(int d);
    return (d == 0);
  endfunction
  function automatic int cfg_par(int d);
    return (d == 2) ? 0 : 1;
  endfunction

  // Word from the received bits, listed in arrival order.
  function automatic logic [31:0] assemble(logic [63:0] bits, int d);
    logic [31:0] w;
    int n;
    w = '0;
    n = cfg_n(d);
    for (int i = 0; i < n; i++) begin
      if (cfg_msb(d)) w[n-1-i] = bits[i];
      else            w[i]     = bits[i];
    end
    return w;
  endfunction

  function automatic logic parity_of(logic [63:0] bits, int cnt);
    logic x;
    x = 1'b0;
    for (int i = 0; i < cnt; i++) x = x ^ bits[i];
    return x;
  endfunction

  // Model state: frame open flag, list of bits received so far, held outputs.
  bit          m_inprog[3] = '{0, 0, 0};
  int          m_nb[3]     = '{0, 0, 0};
  logic [63:0] m_bits[3]   = '{64'd0, 64'd0, 64'd0};
  logic [31:0] m_dout[3]   = '{32'd0, 32'd0, 32'd0};
  bit          m_valid[3]  = '{0, 0, 0};
  bit          m_err[3]    = '{0, 0, 0};

  bit          n_inprog[3];
  int          n_nb[3];
  logic [63:0] n_bits[3];
  logic [31:0] n_dout[3];
  bit          n_valid[3];
  bit          n_err[3];

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      n_inprog[d] = m_inprog[d];
      n_nb[d]     = m_nb[d];
      n_bits[d]   = m_bits[d];
      n_dout[d]   = m_dout[d];
      n_valid[d]  = 1'b0;
      n_err[d]    = m_err[d];
      if (sof) begin
        n_inprog[d] = 1'b1;
        n_nb[d]     = 0;
        n_bits[d]   = '0;
      end else if (m_inprog[d] && bit_en) begin
        n_bits[d][m_nb[d]] = sdin;
        n_nb[d] = m_nb[d] + 1;
        if (n_nb[d] == cfg_n(d) + cfg_par(d)) begin
          n_inprog[d] = 1'b0;
          n_valid[d]  = 1'b1;
          n_dout[d]   = assemble(n_bits[d], d);
          n_err[d]    = (cfg_par(d) != 0) ? parity_of(n_bits[d], n_nb[d]) : 1'b0;
        end
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        m_inprog[d] <= 1'b0;
        m_nb[d]     <= 0;
        m_bits[d]   <= '0;
        m_dout[d]   <= '0;
        m_valid[d]  <= 1'b0;
        m_err[d]    <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_inprog[d] <= n_inprog[d];
        m_nb[d]     <= n_nb[d];
        m_bits[d]   <= n_bits[d];
        m_dout[d]   <= n_dout[d];
        m_valid[d]  <= n_valid[d];
        m_err[d]    <= n_err[d];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every configuration against the model.
  always @(negedge clk) begin
    chk("u0 dout",  32'(dout0),  m_dout[0]);
    chk("u0 valid", 32'(valid0), 32'(m_valid[0]));
    chk("u0 busy",  32'(busy0),  32'(m_inprog[0]));
    chk("u0 err",   32'(err0),   32'(m_err[0]));
    chk("u1 dout",  32'(dout1),  m_dout[1]);
    chk("u1 valid", 32'(valid1), 32'(m_valid[1]));
    chk("u1 busy",  32'(busy1),  32'(m_inprog[1]));
    chk("u1 err",   32'(err1),   32'(m_err[1]));
    chk("u2 dout",  32'(dout2),  m_dout[2]);
    chk("u2 valid", 32'(valid2), 32'(m_valid[2]));
    chk("u2 busy",  32'(busy2),  32'(m_inprog[2]));
    chk("u2 err",   32'(err2),   32'(m_err[2]));
  end

  task automatic send_sof();
    @(posedge clk); #1;
    sof = 1'b1; bit_en = 1'b0; sdin = 1'($urandom);
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      sof = 1'b0; bit_en = 1'b0; sdin = 1'($urandom);
    end
    @(posedge clk); #1;
    sof = 1'b0; bit_en = 1'b1; sdin = b;
  endtask

  // Data bits are sent b[7] first, then the parity bit.
  task automatic send_frame(input logic [7:0] b, input logic par, input int maxgap);
    send_sof();
    for (int i = 7; i >= 0; i--) send_bit(b[i], maxgap);
    send_bit(par, maxgap);
  endtask

  // One cycle after the final bit: completion must be visible on u0/u1.
  task automatic done_check(input string tag, input logic nxt_sof,
                            input logic [7:0] e0, input logic [7:0] e1, input logic eerr);
    @(posedge clk); #1;
    sof = nxt_sof; bit_en = 1'b0; sdin = 1'b0;
    @(negedge clk);
    chk({tag, " u0 valid"}, 32'(valid0), 32'd1);
    chk({tag, " u0 dout"},  32'(dout0),  32'(e0));
    chk({tag, " u0 err"},   32'(err0),   32'(eerr));
    chk({tag, " u1 valid"}, 32'(valid1), 32'd1);
    chk({tag, " u1 dout"},  32'(dout1),  32'(e1));
    chk({tag, " u1 err"},   32'(err1),   32'(eerr));
    chk({tag, " model u0"}, m_dout[0],   32'(e0));
    chk({tag, " model u1"}, m_dout[1],   32'(e1));
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; bit_en = 1'b0; sdin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset u0 dout",  32'(dout0),  32'd0);
    chk("reset u0 busy",  32'(busy0),  32'd0);
    chk("reset u0 valid", 32'(valid0), 32'd0);
    chk("reset u0 err",   32'(err0),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    send_frame(8'b10110010, 1'b0, 0);
    done_check("frame B2 p0", 1'b0, 8'hB2, 8'h4D, 1'b0);
    send_frame(8'b10110010, 1'b1, 2);
    done_check("frame B2 p1", 1'b0, 8'hB2, 8'h4D, 1'b1);
    send_frame(8'b10110010, 1'b0, 5);
    done_check("gappy 4D", 1'b0, 8'hB2, 8'h4D, 1'b0);

    send_sof();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1);
    send_frame(8'hFF, 1'b0, 1);
    done_check("abort FF", 1'b0, 8'hFF, 8'hFF, 1'b0);

    send_sof();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    @(posedge clk); #3;
    bit_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("async rst u0 dout",  32'(dout0),  32'd0);
    chk("async rst u0 busy",  32'(busy0),  32'd0);
    chk("async rst u0 valid", 32'(valid0), 32'd0);
    chk("async rst u1 dout",  32'(dout1),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("no sof u0 dout",  32'(dout0),  32'd0);
    chk("no sof u0 valid", 32'(valid0), 32'd0);

    send_frame(8'h01, 1'b1, 1);
    done_check("b2b first", 1'b1, 8'h01, 8'h80, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(((i == 7) ? 1'b1 : 1'b0), 1);
    send_bit(1'b1, 1);
    done_check("b2b second", 1'b0, 8'h80, 8'h01, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(299, 0) == 0) reset = 1'b1;
      sof    = ($urandom_range(99, 0) < 4);
      bit_en = ($urandom_range(2, 0) != 0);
      sdin   = 1'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; sof = 1'b0; bit_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
